// File: rtl/spi_reg_bank.sv
// SPI register bank: decodes command bytes from an upstream SPI slave and
// serves an 8-entry register map (ID, live status, six RW control registers)
// with auto-incrementing burst reads and writes.
module spi_reg_bank #(
    parameter logic [7:0] ID       = 8'hA5,
    parameter logic [7:0] CTRL_RST = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sel_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] tx_data,
    input  logic [7:0] status_in,
    output logic [7:0] ctrl_out,
    output logic       wr_strobe,
    output logic [2:0] wr_addr,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_DROP  = 3'd4
    } state_t;

    state_t      state_r;
    logic [2:0]  ptr_r;
    // Set once sel_n has been seen high after reset; a frame that was cut by
    // reset must fully end before a new command is accepted.
    logic        armed_r;
    logic [7:0]  regs_r [2:7];
    logic [7:0]  tx_data_r;
    logic [7:0]  err_count_r;
    logic        wr_strobe_r;
    logic [2:0]  wr_addr_r;

    logic [2:0]  rd_addr_s;
    logic [7:0]  rd_data_s;
    logic        wr_en_s;
    logic        cmd_bad_s;

    assign tx_data   = tx_data_r;
    assign ctrl_out  = regs_r[2];
    assign wr_strobe = wr_strobe_r;
    assign wr_addr   = wr_addr_r;
    assign err_count = err_count_r;

    assign cmd_bad_s = (rx_data[6:3] != 4'd0);
    assign wr_en_s   = (state_r == ST_WRITE) && rx_valid && !sel_n && (ptr_r >= 3'd2);

    // Pick the address to read: the command's start address, else the next burst slot.
    always_comb begin
        rd_addr_s = ptr_r + 3'd1;
        if (state_r == ST_CMD) begin
            rd_addr_s = rx_data[2:0];
        end else begin
            rd_addr_s = ptr_r + 3'd1;
        end
    end

    // Register map read multiplexer; status is sampled live at read time.
    always_comb begin
        rd_data_s = 8'h00;
        case (rd_addr_s)
            3'd0:    rd_data_s = ID;
            3'd1:    rd_data_s = status_in;
            3'd2:    rd_data_s = regs_r[2];
            3'd3:    rd_data_s = regs_r[3];
            3'd4:    rd_data_s = regs_r[4];
            3'd5:    rd_data_s = regs_r[5];
            3'd6:    rd_data_s = regs_r[6];
            3'd7:    rd_data_s = regs_r[7];
            default: rd_data_s = 8'h00;
        endcase
    end

    // Writable register storage (addresses 2..7).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 2; i < 8; i++) begin
                regs_r[i] <= CTRL_RST;
            end
        end else begin
            for (int i = 2; i < 8; i++) begin
                if (wr_en_s && (ptr_r == 3'(i))) begin
                    regs_r[i] <= rx_data;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Frame FSM with burst pointer, read data, write strobe and error counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 3'd0;
            armed_r     <= 1'b0;
            tx_data_r   <= 8'h00;
            wr_strobe_r <= 1'b0;
            wr_addr_r   <= 3'd0;
            err_count_r <= 8'h00;
        end else begin
            wr_strobe_r <= 1'b0;
            if (sel_n) begin
                // Frame ends; any byte arriving on this same edge is dropped.
                state_r   <= ST_IDLE;
                armed_r   <= 1'b1;
                tx_data_r <= 8'h00;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        tx_data_r <= 8'h00;
                        if (armed_r) begin
                            state_r <= ST_CMD;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_CMD: begin
                        if (rx_valid) begin
                            if (cmd_bad_s) begin
                                state_r   <= ST_DROP;
                                tx_data_r <= 8'h00;
                                if (err_count_r != 8'hFF) begin
                                    err_count_r <= err_count_r + 8'd1;
                                end else begin
                                    err_count_r <= err_count_r;
                                end
                            end else if (rx_data[7]) begin
                                state_r   <= ST_WRITE;
                                ptr_r     <= rx_data[2:0];
                                tx_data_r <= 8'h00;
                            end else begin
                                state_r   <= ST_READ;
                                ptr_r     <= rx_data[2:0];
                                tx_data_r <= rd_data_s;
                            end
                        end else begin
                            tx_data_r <= 8'h00;
                        end
                    end
                    ST_WRITE: begin
                        tx_data_r <= 8'h00;
                        if (rx_valid) begin
                            // Addresses 0 and 1 are read-only: skip but still advance.
                            if (ptr_r >= 3'd2) begin
                                wr_strobe_r <= 1'b1;
                                wr_addr_r   <= ptr_r;
                            end else begin
                                wr_strobe_r <= 1'b0;
                            end
                            ptr_r <= ptr_r + 3'd1;
                        end else begin
                            ptr_r <= ptr_r;
                        end
                    end
                    ST_READ: begin
                        if (rx_valid) begin
                            ptr_r     <= ptr_r + 3'd1;
                            tx_data_r <= rd_data_s;
                        end else begin
                            tx_data_r <= tx_data_r;
                        end
                    end
                    ST_DROP: begin
                        tx_data_r <= 8'h00;
                    end
                    default: begin
                        state_r   <= ST_IDLE;
                        tx_data_r <= 8'h00;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed self-checking bench for spi_reg_bank.
module tb_spi_reg_bank;

    localparam logic [7:0] ID_V   = 8'hA5;
    localparam logic [7:0] CRST   = 8'h96;
    localparam logic [7:0] STATUS = 8'h3C;

    logic       clk;
    logic       rst_n;
    logic       sel_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic [7:0] status_in;
    logic [7:0] ctrl_out;
    logic       wr_strobe;
    logic [2:0] wr_addr;
    logic [7:0] err_count;

    int errors = 0;
    int checks = 0;

    spi_reg_bank #(.ID(ID_V), .CTRL_RST(CRST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel_n     (sel_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_data   (tx_data),
        .status_in (status_in),
        .ctrl_out  (ctrl_out),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic start_frame();
        sel_n = 1'b0;
        tick();
    endtask

    task automatic end_frame();
        sel_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx: got %h exp %h", tx_data, 8'h00); end
        checks++; if (ctrl_out !== CRST) begin errors++; $display("FAIL reset_ctrl: got %h exp %h", ctrl_out, CRST); end
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b exp 0", wr_strobe); end
        checks++; if (wr_addr !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d exp 0", wr_addr); end
        checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_err: got %h exp 00", err_count); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        start_frame();
        send_byte(8'h82);
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL wr_cmd_nostrobe: got %b exp 0", wr_strobe); end
        send_byte(8'h5A);
        checks++; if (wr_strobe !== 1'b1) begin errors++; $display("FAIL wr_strobe: got %b exp 1", wr_strobe); end
        checks++; if (wr_addr !== 3'd2) begin errors++; $display("FAIL wr_addr: got %0d exp 2", wr_addr); end
        checks++; if (ctrl_out !== 8'h5A) begin errors++; $display("FAIL wr_ctrl: got %h exp 5a", ctrl_out); end
        tick();
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL wr_strobe_pulse: got %b exp 0", wr_strobe); end
        end_frame();
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL wr_idle_tx: got %h exp 00", tx_data); end
    endtask

    task automatic test_read();
        start_frame();
        send_byte(8'h00);
        checks++; if (tx_data !== ID_V) begin errors++; $display("FAIL rd_id: got %h exp %h", tx_data, ID_V); end
        send_byte(8'hFF);
        checks++; if (tx_data !== STATUS) begin errors++; $display("FAIL rd_status: got %h exp %h", tx_data, STATUS); end
        tick();
        checks++; if (tx_data !== STATUS) begin errors++; $display("FAIL rd_hold: got %h exp %h", tx_data, STATUS); end
        send_byte(8'hFF);
        checks++; if (tx_data !== 8'h5A) begin errors++; $display("FAIL rd_reg2: got %h exp 5a", tx_data); end
        end_frame();
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rd_end_tx: got %h exp 00", tx_data); end
    endtask

    task automatic test_wrap();
        start_frame();
        send_byte(8'h87);
        send_byte(8'h11);
        checks++; if (wr_strobe !== 1'b1 || wr_addr !== 3'd7) begin errors++; $display("FAIL wrap_wr7: got strobe=%b addr=%0d exp strobe=1 addr=7", wr_strobe, wr_addr); end
        send_byte(8'h22);
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL wrap_addr0_discard: got %b exp 0", wr_strobe); end
        send_byte(8'h33);
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL wrap_addr1_discard: got %b exp 0", wr_strobe); end
        checks++; if (ctrl_out !== 8'h5A) begin errors++; $display("FAIL wrap_ctrl_kept: got %h exp 5a", ctrl_out); end
        end_frame();
        start_frame();
        send_byte(8'h07);
        checks++; if (tx_data !== 8'h11) begin errors++; $display("FAIL wrap_rd7: got %h exp 11", tx_data); end
        send_byte(8'h00);
        checks++; if (tx_data !== ID_V) begin errors++; $display("FAIL wrap_rd0: got %h exp %h", tx_data, ID_V); end
        send_byte(8'h00);
        checks++; if (tx_data !== STATUS) begin errors++; $display("FAIL wrap_rd1: got %h exp %h", tx_data, STATUS); end
        end_frame();
    endtask

    task automatic test_burst();
        start_frame();
        send_byte(8'h83);
        send_byte(8'hAA);
        checks++; if (wr_strobe !== 1'b1 || wr_addr !== 3'd3) begin errors++; $display("FAIL burst_wr3: got strobe=%b addr=%0d exp strobe=1 addr=3", wr_strobe, wr_addr); end
        send_byte(8'hBB);
        checks++; if (wr_strobe !== 1'b1 || wr_addr !== 3'd4) begin errors++; $display("FAIL burst_wr4: got strobe=%b addr=%0d exp strobe=1 addr=4", wr_strobe, wr_addr); end
        end_frame();
        start_frame();
        send_byte(8'h03);
        checks++; if (tx_data !== 8'hAA) begin errors++; $display("FAIL burst_rd3: got %h exp aa", tx_data); end
        send_byte(8'h00);
        checks++; if (tx_data !== 8'hBB) begin errors++; $display("FAIL burst_rd4: got %h exp bb", tx_data); end
        send_byte(8'h00);
        checks++; if (tx_data !== CRST) begin errors++; $display("FAIL burst_rd5: got %h exp %h", tx_data, CRST); end
        end_frame();
    endtask

    task automatic test_drop();
        start_frame();
        send_byte(8'h48);
        checks++; if (err_count !== 8'h01) begin errors++; $display("FAIL drop_err1: got %h exp 01", err_count); end
        send_byte(8'h9A);
        checks++; if (wr_strobe !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL drop_nowrite: got strobe=%b tx=%h exp strobe=0 tx=00", wr_strobe, tx_data); end
        end_frame();
        start_frame();
        send_byte(8'h02);
        checks++; if (tx_data !== 8'h5A) begin errors++; $display("FAIL drop_reg2_kept: got %h exp 5a", tx_data); end
        end_frame();
        for (int i = 0; i < 253; i++) begin
            start_frame();
            send_byte(8'h48);
            end_frame();
        end
        checks++; if (err_count !== 8'hFE) begin errors++; $display("FAIL drop_err254: got %h exp fe", err_count); end
        for (int i = 0; i < 46; i++) begin
            start_frame();
            send_byte(8'h48);
            end_frame();
        end
        checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL drop_err_sat: got %h exp ff", err_count); end
    endtask

    task automatic test_back_to_back();
        start_frame();
        send_byte(8'h85);
        send_byte(8'h66);
        checks++; if (wr_strobe !== 1'b1 || wr_addr !== 3'd5) begin errors++; $display("FAIL b2b_wr5: got strobe=%b addr=%0d exp strobe=1 addr=5", wr_strobe, wr_addr); end
        sel_n    = 1'b1;
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL b2b_late_byte: got %b exp 0", wr_strobe); end
        start_frame();
        send_byte(8'h05);
        checks++; if (tx_data !== 8'h66) begin errors++; $display("FAIL b2b_rd5: got %h exp 66", tx_data); end
        send_byte(8'h00);
        checks++; if (tx_data !== CRST) begin errors++; $display("FAIL b2b_rd6: got %h exp %h", tx_data, CRST); end
        end_frame();
    endtask

    task automatic test_reset_mid();
        start_frame();
        send_byte(8'h02);
        send_byte(8'h00);
        checks++; if (tx_data !== 8'hAA) begin errors++; $display("FAIL rstmid_pre_rd3: got %h exp aa", tx_data); end
        rst_n = 1'b0;
        tick();
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx: got %h exp 00", tx_data); end
        checks++; if (ctrl_out !== CRST) begin errors++; $display("FAIL rstmid_ctrl: got %h exp %h", ctrl_out, CRST); end
        checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL rstmid_err: got %h exp 00", err_count); end
        rst_n = 1'b1;
        tick();
        send_byte(8'h00);
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_noarm_rd: got %h exp 00", tx_data); end
        send_byte(8'h82);
        send_byte(8'h12);
        checks++; if (wr_strobe !== 1'b0 || ctrl_out !== CRST) begin errors++; $display("FAIL rstmid_noarm_wr: got strobe=%b ctrl=%h exp strobe=0 ctrl=%h", wr_strobe, ctrl_out, CRST); end
        end_frame();
        start_frame();
        send_byte(8'h00);
        checks++; if (tx_data !== ID_V) begin errors++; $display("FAIL rstmid_rearm_id: got %h exp %h", tx_data, ID_V); end
        send_byte(8'h00);
        send_byte(8'h00);
        checks++; if (tx_data !== CRST) begin errors++; $display("FAIL rstmid_reg2: got %h exp %h", tx_data, CRST); end
        end_frame();
    endtask

    initial begin
        rst_n     = 1'b0;
        sel_n     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        status_in = STATUS;
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_burst();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
